// File: rtl/id_stage.sv
// Decode stage: register read, early branch/jump resolution, hazard detection and the ID/EX
// pipeline register. Branches have a single delay slot, so nothing is ever flushed here.
module id_stage #(
    parameter int unsigned RA_REG = 31
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_PR,
    input  logic [31:0] CIA_PR,
    input  logic        STALL_EXT,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [4:0]  dest_MEM,
    input  logic        regwrite_MEM,
    input  logic        memread_MEM,
    input  logic [31:0] alu_result_MEM,
    output logic        taken_branch1,
    output logic [31:0] nextInstruction_address,
    output logic        FREEZE,
    output logic [31:0] opA_EX,
    output logic [31:0] opB_EX,
    output logic [31:0] imm_EX,
    output logic [4:0]  dest_EX,
    output logic [3:0]  aluop_EX,
    output logic        alusrc_EX,
    output logic        regwrite_EX,
    output logic        memread_EX,
    output logic        memwrite_EX,
    output logic        memtoreg_EX
);
    localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
    localparam logic [5:0] OpBne = 6'h05, OpAddi = 6'h08, OpAddiu = 6'h09, OpAndi = 6'h0C;
    localparam logic [5:0] OpOri = 6'h0D, OpLui = 6'h0F, OpLw = 6'h23, OpSw = 6'h2B;
    localparam logic [5:0] FnSll = 6'h00, FnJr = 6'h08, FnAdd = 6'h20, FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24, FnOr = 6'h25, FnSlt = 6'h2A;
    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluAnd = 4'd2, AluOr = 4'd3;
    localparam logic [3:0] AluSlt = 4'd4, AluSll = 4'd5, AluLui = 4'd6;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext_imm, zext_imm, pc_plus4;

    assign opcode   = Instr1_PR[31:26];
    assign rs       = Instr1_PR[25:21];
    assign rt       = Instr1_PR[20:16];
    assign rd       = Instr1_PR[15:11];
    assign shamt    = Instr1_PR[10:6];
    assign funct    = Instr1_PR[5:0];
    assign sext_imm = {{16{Instr1_PR[15]}}, Instr1_PR[15:0]};
    assign zext_imm = {16'b0, Instr1_PR[15:0]};
    assign pc_plus4 = CIA_PR + 32'd4;
    assign rs_addr  = rs;
    assign rt_addr  = rt;

    logic [31:0] dec_opa, dec_opb, dec_imm;
    logic [4:0]  dec_dest;
    logic [3:0]  dec_aluop;
    logic        dec_alusrc, dec_regwrite, dec_memread, dec_memwrite, dec_memtoreg;
    logic        use_rs, use_rt, is_beq, is_bne, is_j, is_jal, is_jr;

    always_comb begin
        dec_opa = rs_data;
        dec_opb = rt_data;
        dec_imm = sext_imm;
        dec_dest = 5'd0;
        dec_aluop = AluAdd;
        dec_alusrc = 1'b0;
        dec_regwrite = 1'b0;
        dec_memread = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_j = 1'b0;
        is_jal = 1'b0;
        is_jr = 1'b0;
        if (Instr1_PR != 32'd0) begin
            case (opcode)
                OpRtype: begin
                    dec_dest = rd;
                    dec_regwrite = 1'b1;
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                    case (funct)
                        FnAdd: dec_aluop = AluAdd;
                        FnSub: dec_aluop = AluSub;
                        FnAnd: dec_aluop = AluAnd;
                        FnOr:  dec_aluop = AluOr;
                        FnSlt: dec_aluop = AluSlt;
                        FnSll: begin
                            // Shift source rides on opA, shift amount on imm.
                            dec_aluop = AluSll;
                            dec_opa = rt_data;
                            dec_imm = {27'b0, shamt};
                            dec_alusrc = 1'b1;
                            use_rs = 1'b0;
                        end
                        FnJr: begin
                            dec_dest = 5'd0;
                            dec_regwrite = 1'b0;
                            use_rt = 1'b0;
                            is_jr = 1'b1;
                        end
                        default: begin
                            dec_dest = 5'd0;
                            dec_regwrite = 1'b0;
                            use_rs = 1'b0;
                            use_rt = 1'b0;
                        end
                    endcase
                end
                OpAddi, OpAddiu, OpAndi, OpOri: begin
                    dec_dest = rt;
                    dec_regwrite = 1'b1;
                    dec_alusrc = 1'b1;
                    use_rs = 1'b1;
                    if (opcode == OpAndi || opcode == OpOri) begin
                        dec_imm = zext_imm;
                        dec_aluop = (opcode == OpAndi) ? AluAnd : AluOr;
                    end
                end
                OpLui: begin
                    dec_dest = rt;
                    dec_regwrite = 1'b1;
                    dec_alusrc = 1'b1;
                    dec_aluop = AluLui;
                    dec_imm = {Instr1_PR[15:0], 16'b0};
                end
                OpLw: begin
                    dec_dest = rt;
                    dec_regwrite = 1'b1;
                    dec_alusrc = 1'b1;
                    dec_memread = 1'b1;
                    dec_memtoreg = 1'b1;
                    use_rs = 1'b1;
                end
                OpSw: begin
                    dec_alusrc = 1'b1;
                    dec_memwrite = 1'b1;
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                OpBeq, OpBne: begin
                    is_beq = (opcode == OpBeq);
                    is_bne = (opcode == OpBne);
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                OpJ: is_j = 1'b1;
                OpJal: begin
                    is_jal = 1'b1;
                    dec_dest = 5'(RA_REG);
                    dec_regwrite = 1'b1;
                    dec_opa = CIA_PR + 32'd8;
                    dec_opb = 32'd0;
                end
                default: ;
            endcase
        end
        if (dec_dest == 5'd0) dec_regwrite = 1'b0;
    end

    logic        br_rs, br_rt, hz, eq, taken_raw;
    logic [31:0] fwd_rs, fwd_rt, target;

    assign br_rs = is_beq | is_bne | is_jr;
    assign br_rt = is_beq | is_bne;

    always_comb begin
        hz = 1'b0;
        if (memread_EX && dest_EX != 5'd0 &&
            ((use_rs && dest_EX == rs) || (use_rt && dest_EX == rt))) hz = 1'b1;
        if (regwrite_EX && ((br_rs && dest_EX == rs) || (br_rt && dest_EX == rt))) hz = 1'b1;
        if (memread_MEM && dest_MEM != 5'd0 &&
            ((br_rs && dest_MEM == rs) || (br_rt && dest_MEM == rt))) hz = 1'b1;
    end

    // Loads in MEM are excluded from forwarding; the hazard logic stalls for them instead.
    assign fwd_rs = (regwrite_MEM && !memread_MEM && dest_MEM != 5'd0 && dest_MEM == rs) ?
                    alu_result_MEM : rs_data;
    assign fwd_rt = (regwrite_MEM && !memread_MEM && dest_MEM != 5'd0 && dest_MEM == rt) ?
                    alu_result_MEM : rt_data;
    assign eq = (fwd_rs == fwd_rt);
    assign taken_raw = (is_beq && eq) || (is_bne && !eq) || is_j || is_jal || is_jr;

    always_comb begin
        target = 32'd0;
        if (is_beq || is_bne) target = pc_plus4 + {sext_imm[29:0], 2'b00};
        else if (is_j || is_jal) target = {pc_plus4[31:28], Instr1_PR[25:0], 2'b00};
        else if (is_jr) target = fwd_rs;
    end

    assign FREEZE = RESET & (hz | STALL_EXT);
    assign taken_branch1 = RESET & taken_raw & ~FREEZE;
    assign nextInstruction_address = RESET ? target : 32'd0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            opA_EX <= '0;
            opB_EX <= '0;
            imm_EX <= '0;
            dest_EX <= '0;
            aluop_EX <= '0;
            alusrc_EX <= 1'b0;
            regwrite_EX <= 1'b0;
            memread_EX <= 1'b0;
            memwrite_EX <= 1'b0;
            memtoreg_EX <= 1'b0;
        end else if (!STALL_EXT) begin
            if (hz) begin
                opA_EX <= '0;
                opB_EX <= '0;
                imm_EX <= '0;
                dest_EX <= '0;
                aluop_EX <= '0;
                alusrc_EX <= 1'b0;
                regwrite_EX <= 1'b0;
                memread_EX <= 1'b0;
                memwrite_EX <= 1'b0;
                memtoreg_EX <= 1'b0;
            end else begin
                opA_EX <= dec_opa;
                opB_EX <= dec_opb;
                imm_EX <= dec_imm;
                dest_EX <= dec_dest;
                aluop_EX <= dec_aluop;
                alusrc_EX <= dec_alusrc;
                regwrite_EX <= dec_regwrite;
                memread_EX <= dec_memread;
                memwrite_EX <= dec_memwrite;
                memtoreg_EX <= dec_memtoreg;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, branch resolution, forwarding, hazard stalls, external
// stall and asynchronous reset, with hand-computed expectations.
module tb_id_stage;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Instr1_PR, CIA_PR, rs_data, rt_data, alu_result_MEM;
    logic        STALL_EXT, regwrite_MEM, memread_MEM;
    logic [4:0]  dest_MEM, rs_addr, rt_addr, dest_EX;
    logic        taken_branch1, FREEZE;
    logic [31:0] nextInstruction_address, opA_EX, opB_EX, imm_EX;
    logic [3:0]  aluop_EX;
    logic        alusrc_EX, regwrite_EX, memread_EX, memwrite_EX, memtoreg_EX;

    int passed = 0;
    int total = 0;

    id_stage #(.RA_REG(31)) dut (
        .CLK(CLK), .RESET(RESET), .Instr1_PR(Instr1_PR), .CIA_PR(CIA_PR),
        .STALL_EXT(STALL_EXT), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .dest_MEM(dest_MEM),
        .regwrite_MEM(regwrite_MEM), .memread_MEM(memread_MEM),
        .alu_result_MEM(alu_result_MEM), .taken_branch1(taken_branch1),
        .nextInstruction_address(nextInstruction_address), .FREEZE(FREEZE),
        .opA_EX(opA_EX), .opB_EX(opB_EX), .imm_EX(imm_EX), .dest_EX(dest_EX),
        .aluop_EX(aluop_EX), .alusrc_EX(alusrc_EX), .regwrite_EX(regwrite_EX),
        .memread_EX(memread_EX), .memwrite_EX(memwrite_EX), .memtoreg_EX(memtoreg_EX)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mem();
        dest_MEM = 5'd0;
        regwrite_MEM = 1'b0;
        memread_MEM = 1'b0;
        alu_result_MEM = 32'd0;
    endtask

    initial begin
        RESET = 1'b0;
        Instr1_PR = 32'd0;
        CIA_PR = 32'd0;
        STALL_EXT = 1'b0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        clear_mem();
        #2;
        chk("rst0_dest", dest_EX, 0);
        chk("rst0_freeze", FREEZE, 0);
        RESET = 1'b1;
        step();

        // ADD $4,$3,$5 loaded, then async reset clears it without a clock edge
        Instr1_PR = 32'h00652020; rs_data = 32'd1; rt_data = 32'd2;
        step();
        chk("add_regwrite", regwrite_EX, 1);
        chk("add_dest", dest_EX, 4);
        chk("add_opA", opA_EX, 1);
        chk("add_opB", opB_EX, 2);
        #2 RESET = 1'b0;
        #1;
        chk("arst_regwrite", regwrite_EX, 0);
        chk("arst_dest", dest_EX, 0);
        chk("arst_opA", opA_EX, 0);
        chk("arst_opB", opB_EX, 0);
        chk("arst_taken", taken_branch1, 0);
        chk("arst_nia", nextInstruction_address, 0);
        RESET = 1'b1;
        step();

        // ADDI $2,$1,-4
        Instr1_PR = 32'h2022FFFC; rs_data = 32'd10; rt_data = 32'd0;
        step();
        chk("addi_opA", opA_EX, 10);
        chk("addi_imm", imm_EX, 32'hFFFFFFFC);
        chk("addi_alusrc", alusrc_EX, 1);
        chk("addi_regwrite", regwrite_EX, 1);
        chk("addi_dest", dest_EX, 2);
        chk("addi_aluop", aluop_EX, 0);

        // BEQ $1,$5,+3 at 0x100
        Instr1_PR = 32'h10250003; CIA_PR = 32'h100; rs_data = 32'd7; rt_data = 32'd7;
        #1;
        chk("beq_eq_taken", taken_branch1, 1);
        chk("beq_target", nextInstruction_address, 32'h110);
        chk("beq_freeze", FREEZE, 0);
        rt_data = 32'd8;
        #1 chk("beq_ne_taken", taken_branch1, 0);
        Instr1_PR = 32'h14250003;
        #1 chk("bne_ne_taken", taken_branch1, 1);
        chk("bne_target", nextInstruction_address, 32'h110);
        // forwarding from MEM makes the operands equal
        Instr1_PR = 32'h10250003; rs_data = 32'd7; rt_data = 32'd9;
        dest_MEM = 5'd5; regwrite_MEM = 1'b1; alu_result_MEM = 32'd7;
        #1 chk("beq_fwd_taken", taken_branch1, 1);
        memread_MEM = 1'b1;
        #1 chk("beq_memload_freeze", FREEZE, 1);
        chk("beq_memload_taken", taken_branch1, 0);
        clear_mem();
        step();
        chk("beq_ex_regwrite", regwrite_EX, 0);

        // JR $1 and J
        Instr1_PR = 32'h00200008; rs_data = 32'h1234;
        #1 chk("jr_taken", taken_branch1, 1);
        chk("jr_target", nextInstruction_address, 32'h1234);
        Instr1_PR = 32'h08000040; CIA_PR = 32'h10000000;
        #1 chk("j_taken", taken_branch1, 1);
        chk("j_target", nextInstruction_address, 32'h10000100);

        // LW $3 then ADD $4,$3,$5: one bubble
        Instr1_PR = 32'h8C230000; rs_data = 32'd0;
        step();
        chk("lw_memread", memread_EX, 1);
        chk("lw_memtoreg", memtoreg_EX, 1);
        chk("lw_dest", dest_EX, 3);
        Instr1_PR = 32'h00652020;
        #1 chk("ldu_freeze", FREEZE, 1);
        step();
        chk("ldu_bubble_regwrite", regwrite_EX, 0);
        chk("ldu_bubble_dest", dest_EX, 0);
        dest_MEM = 5'd3; memread_MEM = 1'b1; regwrite_MEM = 1'b1;
        #1 chk("ldu_release", FREEZE, 0);
        step();
        clear_mem();
        chk("ldu_add_dest", dest_EX, 4);
        chk("ldu_add_regwrite", regwrite_EX, 1);

        // LW $3 then BEQ $3,$0,+2 at 0x200: two freeze cycles
        Instr1_PR = 32'h8C230000;
        step();
        Instr1_PR = 32'h10600002; CIA_PR = 32'h200; rs_data = 32'd5; rt_data = 32'd0;
        #1 chk("ldbr_freeze1", FREEZE, 1);
        chk("ldbr_taken1", taken_branch1, 0);
        step();
        chk("ldbr_bubble_memread", memread_EX, 0);
        dest_MEM = 5'd3; memread_MEM = 1'b1; regwrite_MEM = 1'b1;
        #1 chk("ldbr_freeze2", FREEZE, 1);
        chk("ldbr_taken2", taken_branch1, 0);
        step();
        clear_mem();
        rs_data = 32'd0;
        #1 chk("ldbr_freeze3", FREEZE, 0);
        chk("ldbr_taken3", taken_branch1, 1);
        chk("ldbr_target", nextInstruction_address, 32'h20C);

        // ADDI $1 in EX then JR $1: branch-operand stall
        Instr1_PR = 32'h20210001;
        step();
        Instr1_PR = 32'h00200008; rs_data = 32'h300;
        #1 chk("exbr_freeze", FREEZE, 1);
        chk("exbr_taken", taken_branch1, 0);
        step();
        chk("exbr_bubble_dest", dest_EX, 0);
        chk("exbr_release_taken", taken_branch1, 1);

        // JAL at 0x40 under a 3-cycle external stall
        Instr1_PR = 32'h2022FFFC; rs_data = 32'd10;
        step();
        Instr1_PR = 32'h0C000080; CIA_PR = 32'h40; rs_data = 32'd99; STALL_EXT = 1'b1;
        #1 chk("stall_freeze", FREEZE, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_dest", dest_EX, 2);
            chk("stall_hold_opA", opA_EX, 10);
            chk("stall_taken", taken_branch1, 0);
        end
        STALL_EXT = 1'b0;
        #1 chk("jal_taken", taken_branch1, 1);
        chk("jal_target", nextInstruction_address, 32'h200);
        step();
        chk("jal_dest", dest_EX, 31);
        chk("jal_opA", opA_EX, 32'h48);
        chk("jal_opB", opB_EX, 0);
        chk("jal_regwrite", regwrite_EX, 1);
        chk("jal_alusrc", alusrc_EX, 0);

        // undefined opcode, NOP, write to $0
        Instr1_PR = 32'hFC000000;
        step();
        chk("undef_regwrite", regwrite_EX, 0);
        chk("undef_dest", dest_EX, 0);
        Instr1_PR = 32'h2022FFFC;
        step();
        Instr1_PR = 32'h00000000;
        step();
        chk("nop_regwrite", regwrite_EX, 0);
        chk("nop_alusrc", alusrc_EX, 0);
        Instr1_PR = 32'h2022FFFC;
        step();
        Instr1_PR = 32'h20200005;
        step();
        chk("r0_regwrite", regwrite_EX, 0);

        // LUI, ORI, SW, SUB, SLT
        Instr1_PR = 32'h3C061234;
        step();
        chk("lui_imm", imm_EX, 32'h12340000);
        chk("lui_aluop", aluop_EX, 6);
        chk("lui_dest", dest_EX, 6);
        Instr1_PR = 32'h34278001;
        step();
        chk("ori_imm", imm_EX, 32'h00008001);
        chk("ori_aluop", aluop_EX, 3);
        Instr1_PR = 32'hAC230000;
        step();
        chk("sw_memwrite", memwrite_EX, 1);
        chk("sw_regwrite", regwrite_EX, 0);
        Instr1_PR = 32'h00652022;
        step();
        chk("sub_aluop", aluop_EX, 1);
        Instr1_PR = 32'h0065202A;
        step();
        chk("slt_aluop", aluop_EX, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
